// File: rtl/pwm_cfg_seq.sv
// pwm_cfg_seq: programs one PWM channel through a simple register-write port.
// A request writes, in order: control=0 (channel off), divisor, period,
// duty (clamped to period) and finally the requested control word.
// Each register write is a setup cycle followed by a single strobe cycle.
// Optional build macro PWM_CFG_SEQ_READBACK_EN adds one read cycle after
// every strobe; the returned data is compared with what was written and
// any difference is reported through err_o at done.
module pwm_cfg_seq #(
   parameter logic [7:0] BASE_ADDR = 8'd0,
   parameter logic [7:0] CH_STRIDE = 8'd16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cfg_valid_i,
   output logic        cfg_ready_o,
   input  logic        cfg_ch_i,
   input  logic [31:0] cfg_div_i,
   input  logic [31:0] cfg_period_i,
   input  logic [31:0] cfg_duty_i,
   input  logic [31:0] cfg_ctrl_i,
   output logic        done_o,
   output logic        err_o,
   output logic        busy_o,
   output logic        pwm_write_o,
   output logic [7:0]  pwm_addr_o,
   output logic [31:0] pwm_wdata_o,
   input  logic [31:0] pwm_rdata_i
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_OFF,
      S_DIV,
      S_PER,
      S_DUTY,
      S_CTRL,
      S_DONE
   } state_t;

   // Register offsets inside one channel bank.
   localparam logic [7:0] OFF_CTRL = 8'd0;
   localparam logic [7:0] OFF_DIV  = 8'd4;
   localparam logic [7:0] OFF_PER  = 8'd8;
   localparam logic [7:0] OFF_DUTY = 8'd12;

   // Phase 0 = setup, 1 = strobe, 2 = readback (only with readback build).
`ifdef PWM_CFG_SEQ_READBACK_EN
   localparam logic [1:0] LAST_PH = 2'd2;
`else
   localparam logic [1:0] LAST_PH = 2'd1;
`endif

   state_t      state_q, state_d;
   logic [1:0]  phase_q, phase_d;
   logic        ready_q, ready_d;
   logic        err_q, err_d;
   logic [7:0]  addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        ch_q, ch_d;
   logic [31:0] div_q, div_d;
   logic [31:0] per_q, per_d;
   logic [31:0] duty_q, duty_d;
   logic [31:0] ctrl_q, ctrl_d;
   logic        in_write;

`ifndef PWM_CFG_SEQ_READBACK_EN
   // Read data is meaningless without readback; keep it visibly consumed.
   logic unused_rdata;
   assign unused_rdata = ^pwm_rdata_i;
`endif

   // Byte address of a channel register, 8-bit wrap-around.
   function automatic logic [7:0] reg_addr(input logic ch, input logic [7:0] off);
      logic [7:0] bank;
      bank = ch ? CH_STRIDE : 8'd0;
      return BASE_ADDR + bank + off;
   endfunction

   assign in_write = (state_q == S_OFF) || (state_q == S_DIV) || (state_q == S_PER) ||
                     (state_q == S_DUTY) || (state_q == S_CTRL);

   assign cfg_ready_o = ready_q;
   assign busy_o      = (state_q != S_IDLE);
   assign pwm_write_o = in_write && (phase_q == 2'd1);
   assign done_o      = (state_q == S_DONE);
   assign err_o       = done_o && err_q;
   assign pwm_addr_o  = addr_q;
   assign pwm_wdata_o = wdata_q;

   // State and datapath registers; reset aborts any sequence in flight.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         phase_q <= 2'd0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= 8'd0;
         wdata_q <= 32'd0;
         ch_q    <= 1'b0;
         div_q   <= 32'd0;
         per_q   <= 32'd0;
         duty_q  <= 32'd0;
         ctrl_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ch_q    <= ch_d;
         div_q   <= div_d;
         per_q   <= per_d;
         duty_q  <= duty_d;
         ctrl_q  <= ctrl_d;
      end
   end

   // Next-state logic: sequence the five writes and preload the address and
   // data of each write on entry so they are stable through setup and strobe.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      err_d   = err_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ch_d    = ch_q;
      div_d   = div_q;
      per_d   = per_q;
      duty_d  = duty_q;
      ctrl_d  = ctrl_q;

      case (state_q)
         S_IDLE: begin
            if (cfg_valid_i && ready_q) begin
               ch_d    = cfg_ch_i;
               div_d   = cfg_div_i;
               per_d   = cfg_period_i;
               duty_d  = (cfg_duty_i > cfg_period_i) ? cfg_period_i : cfg_duty_i;
               ctrl_d  = cfg_ctrl_i;
               err_d   = (cfg_period_i == 32'd0) || (cfg_duty_i > cfg_period_i);
               phase_d = 2'd0;
               if (cfg_period_i == 32'd0) begin
                  // Nothing sensible to program: report failure immediately.
                  state_d = S_DONE;
               end else begin
                  state_d = S_OFF;
                  addr_d  = reg_addr(cfg_ch_i, OFF_CTRL);
                  wdata_d = 32'd0;
               end
            end
         end

         S_OFF, S_DIV, S_PER, S_DUTY, S_CTRL: begin
`ifdef PWM_CFG_SEQ_READBACK_EN
            if ((phase_q == 2'd2) && (pwm_rdata_i != wdata_q)) begin
               err_d = 1'b1;
            end
`endif
            if (phase_q == LAST_PH) begin
               phase_d = 2'd0;
               case (state_q)
                  S_OFF: begin
                     state_d = S_DIV;
                     addr_d  = reg_addr(ch_q, OFF_DIV);
                     wdata_d = div_q;
                  end
                  S_DIV: begin
                     state_d = S_PER;
                     addr_d  = reg_addr(ch_q, OFF_PER);
                     wdata_d = per_q;
                  end
                  S_PER: begin
                     state_d = S_DUTY;
                     addr_d  = reg_addr(ch_q, OFF_DUTY);
                     wdata_d = duty_q;
                  end
                  S_DUTY: begin
                     state_d = S_CTRL;
                     addr_d  = reg_addr(ch_q, OFF_CTRL);
                     wdata_d = ctrl_q;
                  end
                  default: begin
                     // Last write done; address/data keep their final value.
                     state_d = S_DONE;
                  end
               endcase
            end else begin
               phase_d = phase_q + 2'd1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            addr_d  = 8'd0;
            wdata_d = 32'd0;
         end

         default: begin
            state_d = S_IDLE;
            phase_d = 2'd0;
            addr_d  = 8'd0;
            wdata_d = 32'd0;
         end
      endcase
   end

   // Ready is registered so it rises one clock after leaving reset or DONE.
   always_comb begin
      ready_d = (state_d == S_IDLE);
   end

endmodule

// File: tb/tb_pwm_cfg_seq.sv
// Testbench for pwm_cfg_seq: directed vectors plus random requests checked
// against a transaction-level model of the expected register writes.
// Build with +define+PWM_CFG_SEQ_READBACK_EN to exercise the readback variant.
module tb_pwm_cfg_seq;

   localparam logic [7:0] BASE   = 8'd0;
   localparam logic [7:0] STRIDE = 8'd16;
`ifdef PWM_CFG_SEQ_READBACK_EN
   localparam int  SLOT = 3;
   localparam bit  RB   = 1'b1;
`else
   localparam int  SLOT = 2;
   localparam bit  RB   = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        cfg_valid;
   logic        cfg_ready;
   logic        cfg_ch;
   logic [31:0] cfg_div, cfg_period, cfg_duty, cfg_ctrl;
   logic        done, err, busy, pwm_write;
   logic [7:0]  pwm_addr;
   logic [31:0] pwm_wdata, pwm_rdata;

   int n_checks = 0;
   int n_errors = 0;

   // Simple PWM register file with an optional corrupted duty readback.
   logic [31:0] mem [256];
   logic        corrupt_duty;
   logic [7:0]  duty_addr_c;

   pwm_cfg_seq #(.BASE_ADDR(BASE), .CH_STRIDE(STRIDE)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_ch_i(cfg_ch),
      .cfg_div_i(cfg_div), .cfg_period_i(cfg_period), .cfg_duty_i(cfg_duty),
      .cfg_ctrl_i(cfg_ctrl), .done_o(done), .err_o(err), .busy_o(busy),
      .pwm_write_o(pwm_write), .pwm_addr_o(pwm_addr), .pwm_wdata_o(pwm_wdata),
      .pwm_rdata_i(pwm_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pwm_write) mem[pwm_addr] <= pwm_wdata;
   end

   always_comb begin
      pwm_rdata = mem[pwm_addr];
      if (corrupt_duty && (pwm_addr == duty_addr_c)) pwm_rdata = mem[pwm_addr] - 32'd1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int w = 0;
      while (!cfg_ready && w < 50) begin
         tick();
         w++;
      end
      check_eq("ready_wait", {31'd0, cfg_ready}, 32'd1);
   endtask

   // Drive one request and compare all observed activity with the model.
   task automatic run_req(input logic ch, input logic [31:0] dv, input logic [31:0] per,
                          input logic [31:0] dt, input logic [31:0] ct, input logic corrupt,
                          input string name);
      logic [7:0]  b;
      logic [7:0]  exp_addr[$];
      logic [31:0] exp_data[$];
      logic [7:0]  got_addr[$];
      logic [31:0] got_data[$];
      int          got_cyc[$];
      int          exp_done, done_cyc, c;
      logic        exp_err, got_err, prev_write;
      logic [7:0]  prev_addr;
      logic [31:0] prev_wdata;

      b = BASE + (ch ? STRIDE : 8'd0);
      if (per != 0) begin
         exp_addr.push_back(b);          exp_data.push_back(32'd0);
         exp_addr.push_back(b + 8'd4);   exp_data.push_back(dv);
         exp_addr.push_back(b + 8'd8);   exp_data.push_back(per);
         exp_addr.push_back(b + 8'd12);  exp_data.push_back((dt > per) ? per : dt);
         exp_addr.push_back(b);          exp_data.push_back(ct);
      end
      exp_done = (per == 0) ? 1 : 1 + 5 * SLOT;
      exp_err  = (per == 0) || (dt > per) || (RB && corrupt);

      wait_ready();
      corrupt_duty = corrupt;
      duty_addr_c  = b + 8'd12;
      cfg_valid = 1'b1; cfg_ch = ch; cfg_div = dv; cfg_period = per; cfg_duty = dt; cfg_ctrl = ct;
      prev_write = 1'b0; prev_addr = pwm_addr; prev_wdata = pwm_wdata;
      tick();
      cfg_valid = 1'b0;
      cfg_ch = $urandom_range(0, 1); cfg_div = $urandom; cfg_period = $urandom;
      cfg_duty = $urandom; cfg_ctrl = $urandom;
      c = 1; done_cyc = -1; got_err = 1'b0;
      while (c <= 40 && done_cyc < 0) begin
         check_eq("busy", {31'd0, busy}, 32'd1);
         check_eq("ready_busy", {31'd0, cfg_ready}, 32'd0);
         if (pwm_write) begin
            got_addr.push_back(pwm_addr);
            got_data.push_back(pwm_wdata);
            got_cyc.push_back(c);
            check_eq("back2back", {31'd0, prev_write}, 32'd0);
            check_eq("setup_addr", {24'd0, prev_addr}, {24'd0, pwm_addr});
            check_eq("setup_data", prev_wdata, pwm_wdata);
         end
         if (done) begin
            done_cyc = c;
            got_err  = err;
            check_eq("done_addr", {24'd0, pwm_addr}, (per == 0) ? 32'd0 : {24'd0, b});
         end else begin
            check_eq("err_no_done", {31'd0, err}, 32'd0);
         end
         prev_write = pwm_write; prev_addr = pwm_addr; prev_wdata = pwm_wdata;
         tick();
         c++;
      end
      if (done_cyc < 0) check_eq("done_timeout", 32'd0, 32'd1);
      check_eq("done_cycle", done_cyc, exp_done);
      check_eq("err", {31'd0, got_err}, {31'd0, exp_err});
      check_eq("ready_after", {31'd0, cfg_ready}, 32'd1);
      check_eq("idle_addr", {24'd0, pwm_addr}, 32'd0);
      check_eq("idle_wdata", pwm_wdata, 32'd0);
      check_eq("idle_busy", {31'd0, busy}, 32'd0);
      check_eq("n_strobes", got_addr.size(), exp_addr.size());
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
         check_eq("strobe_addr", {24'd0, got_addr[i]}, {24'd0, exp_addr[i]});
         check_eq("strobe_data", got_data[i], exp_data[i]);
         check_eq("strobe_cycle", got_cyc[i], 2 + SLOT * i);
      end
      corrupt_duty = 1'b0;
      $display("req %s ch=%0d div=%0d per=%0d duty=%0d ctrl=%0h strobes=%0d done@%0d err=%0d",
               name, ch, dv, per, dt, ct, got_addr.size(), done_cyc, got_err);
   endtask

   // Start a request, reset right after the period strobe, then confirm abort.
   task automatic run_abort(input logic ch);
      logic [7:0]  b;
      logic [31:0] duty_before;
      int          n_str, w;
      b = BASE + (ch ? STRIDE : 8'd0);
      duty_before = mem[b + 8'd12];
      wait_ready();
      cfg_valid = 1'b1; cfg_ch = ch; cfg_div = 32'd3; cfg_period = 32'd40;
      cfg_duty = 32'd20; cfg_ctrl = 32'h5;
      tick();
      cfg_valid = 1'b0;
      n_str = 0; w = 0;
      while (n_str < 3 && w < 40) begin
         if (pwm_write) n_str++;
         if (n_str < 3) tick();
         w++;
      end
      check_eq("abort_reach_period", n_str, 3);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_eq("abort_ready0", {31'd0, cfg_ready}, 32'd0);
      check_eq("abort_busy0", {31'd0, busy}, 32'd0);
      check_eq("abort_addr0", {24'd0, pwm_addr}, 32'd0);
      tick();
      check_eq("abort_ready1", {31'd0, cfg_ready}, 32'd1);
      for (int i = 0; i < 20; i++) begin
         check_eq("abort_no_write", {31'd0, pwm_write}, 32'd0);
         check_eq("abort_no_done", {31'd0, done}, 32'd0);
         tick();
      end
      check_eq("abort_duty_reg", mem[b + 8'd12], duty_before);
      $display("abort ch=%0d after period strobe: strobes_before_reset=%0d", ch, n_str);
   endtask

   initial begin
      rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_div = 0; cfg_period = 0;
      cfg_duty = 0; cfg_ctrl = 0; corrupt_duty = 1'b0; duty_addr_c = 8'd0;
      tick(); tick(); tick();
      check_eq("rst_ready", {31'd0, cfg_ready}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_write", {31'd0, pwm_write}, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd0);
      check_eq("rst_err", {31'd0, err}, 32'd0);
      check_eq("rst_addr", {24'd0, pwm_addr}, 32'd0);
      check_eq("rst_wdata", pwm_wdata, 32'd0);
      rst_n = 1'b1;
      tick();
      check_eq("rst_release_ready", {31'd0, cfg_ready}, 32'd1);

      run_req(1'b0, 32'd2, 32'd10, 32'd6, 32'd7, 1'b0, "basic_ch0");
      run_req(1'b1, 32'd2, 32'd10, 32'd6, 32'd7, 1'b0, "basic_ch1");
      run_req(1'b0, 32'd2, 32'd10, 32'd12, 32'd7, 1'b0, "duty_clamp");
      run_req(1'b0, 32'd2, 32'd10, 32'd10, 32'd7, 1'b0, "duty_eq_period");
      run_req(1'b1, 32'd2, 32'd0, 32'd6, 32'd7, 1'b0, "period_zero");
      run_req(1'b0, 32'd2, 32'd10, 32'd6, 32'd7, 1'b1, "bad_readback");
      run_req(1'b0, 32'd2, 32'd10, 32'd6, 32'd7, 1'b0, "good_readback");
      run_abort(1'b0);
      run_req(1'b0, 32'd9, 32'd100, 32'd33, 32'h81, 1'b0, "after_abort");

      for (int k = 0; k < 25; k++) begin
         logic [31:0] per;
         per = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom_range(1, 60);
         run_req($urandom_range(0, 1), $urandom, per, $urandom_range(0, 70), $urandom,
                 $urandom_range(0, 3) == 0, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pwm_cfg_seq.md
PWM_CFG_SEQ -- requirements
Module: pwm_cfg_seq

Interface
REQ-001 Parameter BASE_ADDR, default 8'd0: PWM register byte address of channel 0 control.
REQ-002 Parameter CH_STRIDE, default 8'd16: byte offset between channel 0 and channel 1 register banks.
REQ-003 clk_i  in  1  single clock; all logic on rising edge.
REQ-004 rst_ni  in  1  reset, synchronous, active-low.
REQ-005 cfg_valid_i  in  1  configuration request present.
REQ-006 cfg_ready_o  out  1  sequencer can accept a request.
REQ-007 cfg_ch_i  in  1  target channel (0 or 1).
REQ-008 cfg_div_i / cfg_period_i / cfg_duty_i / cfg_ctrl_i  in  32 each  divisor, period, duty and control values.
REQ-009 done_o  out  1  one-cycle pulse when a request finishes.
REQ-010 err_o  out  1  valid only with done_o; request completed with error.
REQ-011 busy_o  out  1  sequence in progress.
REQ-012 pwm_write_o  out  1  register write strobe to the PWM peripheral.
REQ-013 pwm_addr_o  out  8  register byte address.
REQ-014 pwm_wdata_o  out  32  register write data.
REQ-015 pwm_rdata_i  in  32  register read data from the PWM peripheral.

Function
REQ-016 The FSM SHALL have states IDLE, OFF, DIV, PER, DUTY, CTRL and DONE.
- IDLE: cfg_ready_o=1. Acceptance is the condition cfg_valid_i && cfg_ready_o.
- All cfg_* inputs SHALL be captured at acceptance. Later changes to them have no effect.
REQ-017 Register address = BASE_ADDR + cfg_ch*CH_STRIDE + offset, using 8-bit wrap-around arithmetic. Offsets: control 0, divisor 4, period 8, duty 12.
REQ-018 Write order SHALL be:
- OFF: control = 0, so the channel is disabled while it is reprogrammed.
- DIV: divisor.
- PER: period.
- DUTY: duty.
- CTRL: control = cfg_ctrl.
REQ-019 Each write state SHALL last 2 cycles:
- Setup cycle: addr and wdata driven, pwm_write_o=0.
- Strobe cycle: addr and wdata held, pwm_write_o=1.
- pwm_write_o SHALL never be high for 2 consecutive cycles.
REQ-020 If cfg_duty > cfg_period (unsigned), the duty write SHALL carry cfg_period and err_o SHALL be 1 at done.
REQ-021 If cfg_period == 0, no register write SHALL occur. The FSM SHALL go straight to DONE, giving done_o=1 and err_o=1 in the cycle after acceptance.
REQ-022 DONE SHALL last 1 cycle: done_o=1, then return to IDLE.
- Accept cycle = 0. Strobes occur at cycles 2, 4, 6, 8 and 10. done_o occurs at cycle 11.
- cfg_ready_o=1 again from cycle 12.
REQ-023 busy_o SHALL be 1 in every state except IDLE.
REQ-024 Outside the strobe cycles, pwm_wdata_o and pwm_addr_o hold their last values. In IDLE they are 0.

Reset
REQ-025 While rst_ni=0 at a clock edge, the FSM SHALL go to IDLE and all outputs SHALL be 0, except cfg_ready_o, which SHALL be 1 after the first clock with rst_ni=1.
REQ-026 Reset during a sequence SHALL abort it:
- No further strobes.
- No done_o.
- PWM registers already written are left as they are.

Configuration
REQ-027 Macro PWM_CFG_SEQ_READBACK_EN SHALL control readback verification.
REQ-028 With PWM_CFG_SEQ_READBACK_EN defined:
- Each strobe cycle SHALL be followed by one read cycle: addr held, pwm_write_o=0.
- In the read cycle, pwm_rdata_i SHALL be compared with the value written.
- Any mismatch SHALL set err_o at done.
- Timing: 3 cycles per register; done_o at cycle 16.
REQ-029 Without the macro, there SHALL be no read cycles, pwm_rdata_i SHALL be ignored, and timing is as in REQ-022.

Verification
REQ-030 ch=0, div=2, period=10, duty=6, ctrl=7 -> strobes (addr,data) = (0,0), (4,2), (8,10), (12,6), (0,7) at cycles 2/4/6/8/10; done_o=1, err_o=0 at cycle 11.
REQ-031 Same values with ch=1 -> addresses 16, 20, 24, 28, 16; identical timing.
REQ-032 period=10, duty=12 -> duty strobe data = 10; done_o=1, err_o=1.
REQ-033 period=0 -> no pwm_write_o pulse; done_o=1, err_o=1 at cycle 1; cfg_ready_o=1 at cycle 2.
REQ-034 rst_ni=0 for 1 cycle right after the period strobe -> pwm_write_o stays 0, no done_o; cfg_ready_o=1 one cycle after release; a new request then runs in full.
REQ-035 Macro defined, bench returns 5 instead of 6 on the duty readback -> done_o at cycle 16 with err_o=1; with correct readback, err_o=0.
